// File: rtl/io_issue_queue_pkg.sv
// Shared backend definitions for the in-order issue queue: default sizes,
// the per-slot entry record and the wakeup tag compare.
package io_issue_queue_pkg;

  localparam int unsigned IQ_QUEUE_SIZE = 8;
  localparam int unsigned IQ_PAYLOAD_W  = 64;
  localparam int unsigned IQ_PREG_W     = 6;

  typedef struct packed {
    logic [IQ_PAYLOAD_W-1:0] payload;
    logic [IQ_PREG_W-1:0]    prs1;
    logic [IQ_PREG_W-1:0]    prs2;
    logic                    rdy1;
    logic                    rdy2;
  } iq_entry_t;

  function automatic logic tag_hit(input logic                 wb_valid,
                                   input logic [IQ_PREG_W-1:0] wb_prd,
                                   input logic [IQ_PREG_W-1:0] tag);
    return wb_valid && (wb_prd == tag);
  endfunction

endpackage

// File: rtl/io_iq_entry.sv
// One issue-queue slot: operand storage, wakeup compare and ready tracking.
module io_iq_entry
  import io_issue_queue_pkg::*;
(
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    wr_en_i,
  input  iq_entry_t               wr_data_i,
  input  logic                    wb_valid_i,
  input  logic [IQ_PREG_W-1:0]    wb_prd_i,
  input  logic                    clr_i,
  output logic                    valid_o,
  output logic                    ready_o,
  output logic [IQ_PAYLOAD_W-1:0] payload_o
);

  logic      valid_q, valid_d;
  iq_entry_t entry_q, entry_d;

  always_comb begin
    valid_d = valid_q;
    entry_d = entry_q;
    if (wr_en_i) begin
      // A writeback in the enqueue cycle must not be missed by the new entry.
      entry_d      = wr_data_i;
      entry_d.rdy1 = wr_data_i.rdy1 | tag_hit(wb_valid_i, wb_prd_i, wr_data_i.prs1);
      entry_d.rdy2 = wr_data_i.rdy2 | tag_hit(wb_valid_i, wb_prd_i, wr_data_i.prs2);
      valid_d      = 1'b1;
    end else begin
      if (valid_q) begin
        if (tag_hit(wb_valid_i, wb_prd_i, entry_q.prs1)) entry_d.rdy1 = 1'b1;
        if (tag_hit(wb_valid_i, wb_prd_i, entry_q.prs2)) entry_d.rdy2 = 1'b1;
      end
      if (clr_i) valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || flush) valid_q <= 1'b0;
    else                valid_q <= valid_d;
  end

  // Storage is deliberately left unreset; valid_q qualifies it.
  always_ff @(posedge clock) begin
    if (!reset) entry_q <= entry_d;
  end

  assign valid_o   = valid_q;
  assign ready_o   = entry_q.rdy1 & entry_q.rdy2;
  assign payload_o = entry_q.payload;

endmodule

// File: rtl/io_issue_queue.sv
// In-order issue queue: circular buffer of io_iq_entry slots addressed by
// one-hot enqueue/dequeue pointers, issuing only from the head.
module io_issue_queue
  import io_issue_queue_pkg::*;
#(
  parameter int unsigned QUEUE_SIZE = IQ_QUEUE_SIZE,
  parameter int unsigned PAYLOAD_W  = IQ_PAYLOAD_W,
  parameter int unsigned PREG_W     = IQ_PREG_W
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          flush,
  input  logic                          enq_valid,
  output logic                          enq_ready,
  input  logic [PAYLOAD_W-1:0]          enq_payload,
  input  logic [PREG_W-1:0]             enq_prs1,
  input  logic [PREG_W-1:0]             enq_prs2,
  input  logic                          enq_src1_rdy,
  input  logic                          enq_src2_rdy,
  input  logic                          wb_valid,
  input  logic [PREG_W-1:0]             wb_prd,
  output logic                          deq_valid,
  input  logic                          deq_ready,
  output logic [PAYLOAD_W-1:0]          deq_payload,
  output logic [$clog2(QUEUE_SIZE):0]   count
);

  localparam int unsigned CNT_W = $clog2(QUEUE_SIZE) + 1;
  localparam logic [QUEUE_SIZE-1:0] PTR_INIT = QUEUE_SIZE'(1);

  logic [QUEUE_SIZE-1:0] enq_ptr_oh_q, enq_ptr_oh_d;
  logic [QUEUE_SIZE-1:0] deq_ptr_oh_q, deq_ptr_oh_d;
  logic [CNT_W-1:0]      count_q, count_d;

  logic [QUEUE_SIZE-1:0] slot_valid;
  logic [QUEUE_SIZE-1:0] slot_ready;
  logic [PAYLOAD_W-1:0]  slot_payload [QUEUE_SIZE];

  logic                  head_valid;
  logic                  head_ready;
  logic [PAYLOAD_W-1:0]  head_payload;
  logic                  enq_fire;
  logic                  deq_fire;
  iq_entry_t             enq_data;

  always_comb begin
    head_valid   = 1'b0;
    head_ready   = 1'b0;
    head_payload = '0;
    for (int unsigned i = 0; i < QUEUE_SIZE; i++) begin
      if (deq_ptr_oh_q[i]) begin
        head_valid   = slot_valid[i];
        head_ready   = slot_ready[i];
        head_payload = slot_payload[i];
      end
    end
  end

  assign enq_ready   = ~reset & ~flush & (count_q != CNT_W'(QUEUE_SIZE));
  assign deq_valid   = ~reset & ~flush & head_valid & head_ready;
  assign deq_payload = head_payload;
  assign count       = count_q;

  assign enq_fire = enq_valid & enq_ready;
  assign deq_fire = deq_valid & deq_ready;

  always_comb begin
    enq_data         = '0;
    enq_data.payload = enq_payload;
    enq_data.prs1    = enq_prs1;
    enq_data.prs2    = enq_prs2;
    enq_data.rdy1    = enq_src1_rdy;
    enq_data.rdy2    = enq_src2_rdy;
  end

  always_comb begin
    enq_ptr_oh_d = enq_ptr_oh_q;
    deq_ptr_oh_d = deq_ptr_oh_q;
    count_d      = count_q;
    if (enq_fire) enq_ptr_oh_d = {enq_ptr_oh_q[QUEUE_SIZE-2:0], enq_ptr_oh_q[QUEUE_SIZE-1]};
    if (deq_fire) deq_ptr_oh_d = {deq_ptr_oh_q[QUEUE_SIZE-2:0], deq_ptr_oh_q[QUEUE_SIZE-1]};
    case ({enq_fire, deq_fire})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      enq_ptr_oh_q <= PTR_INIT;
      deq_ptr_oh_q <= PTR_INIT;
      count_q      <= '0;
    end else begin
      enq_ptr_oh_q <= enq_ptr_oh_d;
      deq_ptr_oh_q <= deq_ptr_oh_d;
      count_q      <= count_d;
    end
  end

  for (genvar g = 0; g < QUEUE_SIZE; g++) begin : g_entry
    io_iq_entry u_entry (
      .clock      (clock),
      .reset      (reset),
      .flush      (flush),
      .wr_en_i    (enq_fire & enq_ptr_oh_q[g]),
      .wr_data_i  (enq_data),
      .wb_valid_i (wb_valid),
      .wb_prd_i   (wb_prd),
      .clr_i      (deq_fire & deq_ptr_oh_q[g]),
      .valid_o    (slot_valid[g]),
      .ready_o    (slot_ready[g]),
      .payload_o  (slot_payload[g])
    );
  end

endmodule

// File: tb/tb_io_issue_queue.sv
// Directed bench for io_issue_queue: vector table plus hand-written
// sequences for steady-state streaming and flush recovery.
module tb_io_issue_queue;

  logic        clock = 1'b0;
  logic        reset, flush;
  logic        enq_valid, enq_ready;
  logic [63:0] enq_payload;
  logic [5:0]  enq_prs1, enq_prs2;
  logic        enq_src1_rdy, enq_src2_rdy;
  logic        wb_valid;
  logic [5:0]  wb_prd;
  logic        deq_valid, deq_ready;
  logic [63:0] deq_payload;
  logic [3:0]  count;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  io_issue_queue #(.QUEUE_SIZE(8), .PAYLOAD_W(64), .PREG_W(6)) dut (
    .clock        (clock),
    .reset        (reset),
    .flush        (flush),
    .enq_valid    (enq_valid),
    .enq_ready    (enq_ready),
    .enq_payload  (enq_payload),
    .enq_prs1     (enq_prs1),
    .enq_prs2     (enq_prs2),
    .enq_src1_rdy (enq_src1_rdy),
    .enq_src2_rdy (enq_src2_rdy),
    .wb_valid     (wb_valid),
    .wb_prd       (wb_prd),
    .deq_valid    (deq_valid),
    .deq_ready    (deq_ready),
    .deq_payload  (deq_payload),
    .count        (count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rst, fl, en;
    logic [63:0] pay;
    logic [5:0]  p1, p2;
    logic        s1, s2, wb;
    logic [5:0]  wbp;
    logic        dr;
    logic        e_er, e_dv;
    logic [3:0]  e_cnt;
    logic [63:0] e_pay;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rst, fl, en, input logic [63:0] pay,
                              input logic [5:0] p1, p2, input logic s1, s2, wb,
                              input logic [5:0] wbp, input logic dr, e_er, e_dv,
                              input logic [3:0] e_cnt, input logic [63:0] e_pay);
    vec_t v;
    v.rst = rst; v.fl = fl; v.en = en; v.pay = pay; v.p1 = p1; v.p2 = p2;
    v.s1 = s1; v.s2 = s2; v.wb = wb; v.wbp = wbp; v.dr = dr;
    v.e_er = e_er; v.e_dv = e_dv; v.e_cnt = e_cnt; v.e_pay = e_pay;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Applies inputs mid-cycle; the following posedge consumes them.
  task automatic drive(input logic fl, en, input logic [63:0] pay,
                       input logic [5:0] p1, p2, input logic s1, s2, wb,
                       input logic [5:0] wbp, input logic dr);
    @(negedge clock);
    reset = 1'b0; flush = fl; enq_valid = en; enq_payload = pay;
    enq_prs1 = p1; enq_prs2 = p2; enq_src1_rdy = s1; enq_src2_rdy = s2;
    wb_valid = wb; wb_prd = wbp; deq_ready = dr;
    #1;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; enq_valid = 1'b0; enq_payload = '0;
    enq_prs1 = '0; enq_prs2 = '0; enq_src1_rdy = 1'b0; enq_src2_rdy = 1'b0;
    wb_valid = 1'b0; wb_prd = '0; deq_ready = 1'b0;
    repeat (2) @(posedge clock);

    // rst fl en pay p1 p2 s1 s2 wb wbp dr | er dv cnt pay
    tbl.push_back(mk(1, 0, 1, 64'h1, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 64'h0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(0, 0, 1, 64'h100 + 64'(i), 1, 2, 1, 1, 0, 0, 0, 1, i > 0, 4'(i), 64'h100));
    tbl.push_back(mk(0, 0, 1, 64'h1FF, 1, 2, 1, 1, 0, 0, 0, 0, 1, 8, 64'h100));
    tbl.push_back(mk(0, 0, 1, 64'h1FE, 1, 2, 1, 1, 0, 0, 1, 0, 1, 8, 64'h100));
    for (int i = 1; i < 8; i++)
      tbl.push_back(mk(0, 0, 0, 64'h0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 4'(8 - i), 64'h100 + 64'(i)));
    tbl.push_back(mk(0, 0, 0, 64'h0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    // late wakeup of source 1 on tag 5
    tbl.push_back(mk(0, 0, 1, 64'h200, 5, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 64'h0, 0, 0, 0, 0, 1, 5, 1, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 64'h0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 64'h200));
    tbl.push_back(mk(0, 0, 0, 64'h0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 64'h200));
    // writeback of tag 9 in the enqueue cycle
    tbl.push_back(mk(0, 0, 1, 64'h300, 1, 9, 1, 0, 1, 9, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 64'h0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 64'h300));
    tbl.push_back(mk(0, 0, 0, 64'h0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 64'h300));
    // stalled head blocks a ready younger entry
    tbl.push_back(mk(0, 0, 1, 64'h400, 12, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 64'h401, 13, 0, 1, 1, 0, 0, 1, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 64'h0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2, 0));
    tbl.push_back(mk(0, 0, 0, 64'h0, 0, 0, 0, 0, 1, 12, 1, 1, 0, 2, 0));
    tbl.push_back(mk(0, 0, 0, 64'h0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 2, 64'h400));
    tbl.push_back(mk(0, 0, 0, 64'h0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 64'h401));
    tbl.push_back(mk(0, 0, 0, 64'h0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));

    foreach (tbl[k]) begin
      @(negedge clock);
      reset = tbl[k].rst; flush = tbl[k].fl; enq_valid = tbl[k].en;
      enq_payload = tbl[k].pay; enq_prs1 = tbl[k].p1; enq_prs2 = tbl[k].p2;
      enq_src1_rdy = tbl[k].s1; enq_src2_rdy = tbl[k].s2;
      wb_valid = tbl[k].wb; wb_prd = tbl[k].wbp; deq_ready = tbl[k].dr;
      #1;
      chk($sformatf("v%0d enq_ready", k), 64'(enq_ready), 64'(tbl[k].e_er));
      chk($sformatf("v%0d deq_valid", k), 64'(deq_valid), 64'(tbl[k].e_dv));
      chk($sformatf("v%0d count", k), 64'(count), 64'(tbl[k].e_cnt));
      if (tbl[k].e_dv) chk($sformatf("v%0d deq_payload", k), deq_payload, tbl[k].e_pay);
    end

    // Streaming at occupancy 3 for 20 ops; both pointers wrap twice.
    for (int k = 0; k < 3; k++) drive(0, 1, 64'h500 + 64'(k), 1, 2, 1, 1, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      drive(0, 1, 64'h503 + 64'(i), 1, 2, 1, 1, 0, 0, 1);
      chk($sformatf("stream%0d deq_valid", i), 64'(deq_valid), 64'd1);
      chk($sformatf("stream%0d payload", i), deq_payload, 64'h500 + 64'(i));
      chk($sformatf("stream%0d count", i), 64'(count), 64'd3);
    end
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 64'h0, 0, 0, 0, 0, 0, 0, 1);
      chk($sformatf("drain%0d payload", k), deq_payload, 64'h514 + 64'(k));
    end
    drive(0, 0, 64'h0, 0, 0, 0, 0, 0, 0, 0);
    chk("drain count", 64'(count), 64'd0);

    // Flush at occupancy 5 with a concurrent enqueue and dequeue.
    for (int k = 0; k < 5; k++) drive(0, 1, 64'h600 + 64'(k), 1, 2, 1, 1, 0, 0, 0);
    drive(1, 1, 64'h6FF, 1, 2, 1, 1, 0, 0, 1);
    chk("flush count_before", 64'(count), 64'd5);
    chk("flush enq_ready", 64'(enq_ready), 64'd0);
    chk("flush deq_valid", 64'(deq_valid), 64'd0);
    drive(0, 1, 64'h700, 1, 2, 1, 1, 0, 0, 0);
    chk("post_flush count", 64'(count), 64'd0);
    chk("post_flush deq_valid", 64'(deq_valid), 64'd0);
    chk("post_flush enq_ready", 64'(enq_ready), 64'd1);
    chk("post_flush enq_ptr", 64'(dut.enq_ptr_oh_q), 64'h01);
    chk("post_flush deq_ptr", 64'(dut.deq_ptr_oh_q), 64'h01);
    drive(0, 0, 64'h0, 0, 0, 0, 0, 0, 0, 0);
    chk("refill count", 64'(count), 64'd1);
    chk("refill deq_valid", 64'(deq_valid), 64'd1);
    chk("refill payload", deq_payload, 64'h700);
    chk("refill enq_ptr", 64'(dut.enq_ptr_oh_q), 64'h02);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
